alu_mul_seq: RTL

//  Multi-cycle 16x16 unsigned multiply sequencer built on the shared 16-bit ALU.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_seq_if.sv | 35 +++
 rtl/alu_mul_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, datapath width and the multiply
// sequencer state encoding.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SGT = 3'b101;
  localparam logic [2:0] ALU_SEQ = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_ITER     = 2'd2,
    ST_DONE     = 2'd3
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Signal bundle between the multiply sequencer, its control unit and the
// shared-ALU arbiter.
interface alu_mul_seq_if;
  import alu_pkg::*;

  // Handshakes: Start is a launch request taken only while the sequencer is
  // idle, and Done is a one-cycle pulse with ProdHi/ProdLo valid. The ALU
  // operands are meaningful and AluOut/AluCarry are consumed only in a cycle
  // where both AluReq and AluGnt are high; otherwise AluA/AluB/AluOp are 0.
  logic             Start;
  logic [ALU_W-1:0] Multiplicand;
  logic [ALU_W-1:0] Multiplier;
  logic             Busy;
  logic             Done;
  logic [ALU_W-1:0] ProdHi;
  logic [ALU_W-1:0] ProdLo;
  logic             AluReq;
  logic             AluGnt;
  logic [ALU_W-1:0] AluA;
  logic [ALU_W-1:0] AluB;
  logic [2:0]       AluOp;
  logic [ALU_W-1:0] AluOut;
  logic             AluCarry;

  modport slave (
    input  Start, Multiplicand, Multiplier, AluGnt, AluOut, AluCarry,
    output Busy, Done, ProdHi, ProdLo, AluReq, AluA, AluB, AluOp
  );

  modport master (
    output Start, Multiplicand, Multiplier, AluGnt, AluOut, AluCarry,
    input  Busy, Done, ProdHi, ProdLo, AluReq, AluA, AluB, AluOp
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16 unsigned multiplier that borrows the shared ALU adder for
// one partial-product add per granted cycle.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int         WIDTH  = ALU_W,
  parameter logic [2:0] ADD_OP = ALU_ADD,
  parameter int         CNT_W  = 5
) (
  input  logic          CLK,
  input  logic          Reset_n,
  alu_mul_seq_if.slave  bus,
  output mul_state_t    o_state
);

  mul_state_t r_state;
  mul_state_t w_state_nxt;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_prod_hi;
  logic [WIDTH-1:0]   r_prod_lo;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_fire;
  logic               w_last;
  logic [2*WIDTH-1:0] w_shift;

  assign w_accept = (r_state == ST_IDLE) && bus.Start;
  assign w_fire   = (r_state == ST_ITER) && bus.AluGnt;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  // Carry lands in the top bit of hi; lo[0] has already been consumed.
  assign w_shift  = {bus.AluCarry, bus.AluOut, r_lo[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.AluReq  = 1'b0;
    bus.AluA    = '0;
    bus.AluB    = '0;
    bus.AluOp   = '0;
    bus.Busy    = (r_state != ST_IDLE);
    bus.Done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Start) w_state_nxt = ST_WAIT_GNT;
      end
      ST_WAIT_GNT: begin
        bus.AluReq = 1'b1;
        if (bus.AluGnt) w_state_nxt = ST_ITER;
      end
      ST_ITER: begin
        bus.AluReq = 1'b1;
        if (bus.AluGnt) begin
          bus.AluA  = r_hi;
          bus.AluB  = r_lo[0] ? r_mcand : '0;
          bus.AluOp = ADD_OP;
          if (w_last) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.Done    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Product registers load with the final shift so they are valid during Done
  // and then hold until the next accepted Start.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else if (w_accept) begin
      r_mcand <= bus.Multiplicand;
      r_hi    <= '0;
      r_lo    <= bus.Multiplier;
      r_cnt   <= '0;
    end else if (w_fire) begin
      r_hi  <= w_shift[2*WIDTH-1:WIDTH];
      r_lo  <= w_shift[WIDTH-1:0];
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_prod_hi <= w_shift[2*WIDTH-1:WIDTH];
        r_prod_lo <= w_shift[WIDTH-1:0];
      end
    end
  end

  assign bus.ProdHi = r_prod_hi;
  assign bus.ProdLo = r_prod_lo;
  assign o_state    = r_state;

endmodule
